// File: rtl/game_sprite_motion.sv
// Sprite position/velocity register block with periodic motion strobe,
// on-screen test and registered raster-pixel coverage test.
module game_sprite_motion #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int X_WIDTH       = 10,
   parameter int Y_WIDTH       = 10,
   parameter int DX_WIDTH      = 2,
   parameter int DY_WIDTH      = 2,
   parameter int SPRITE_WIDTH  = 8,
   parameter int SPRITE_HEIGHT = 8,
   parameter int STROBE_WIDTH  = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sprite_write_xy,
   input  logic                sprite_write_dxy,
   input  logic [X_WIDTH-1:0]  sprite_write_x,
   input  logic [Y_WIDTH-1:0]  sprite_write_y,
   input  logic [DX_WIDTH-1:0] sprite_write_dx,
   input  logic [DY_WIDTH-1:0] sprite_write_dy,
   input  logic                sprite_enable_update,
   input  logic [X_WIDTH-1:0]  pixel_x,
   input  logic [Y_WIDTH-1:0]  pixel_y,
   output logic [X_WIDTH-1:0]  sprite_x,
   output logic [Y_WIDTH-1:0]  sprite_y,
   output logic                sprite_within_screen,
   output logic                sprite_pixel_hit
);

   // Geometry constants widened by one bit so x+size never overflows.
   localparam logic [X_WIDTH:0] L_SPR_W = (X_WIDTH+1)'(SPRITE_WIDTH);
   localparam logic [Y_WIDTH:0] L_SPR_H = (Y_WIDTH+1)'(SPRITE_HEIGHT);
   localparam logic [X_WIDTH:0] L_SCR_W = (X_WIDTH+1)'(SCREEN_WIDTH);
   localparam logic [Y_WIDTH:0] L_SCR_H = (Y_WIDTH+1)'(SCREEN_HEIGHT);

   logic [STROBE_WIDTH-1:0] r_strobe_cnt;
   logic [X_WIDTH-1:0]      r_x;
   logic [Y_WIDTH-1:0]      r_y;
   logic [DX_WIDTH-1:0]     r_dx;
   logic [DY_WIDTH-1:0]     r_dy;
   logic                    r_hit;

   logic                    w_strobe;
   logic                    w_move;
   logic [X_WIDTH-1:0]      w_dx_ext;
   logic [Y_WIDTH-1:0]      w_dy_ext;
   logic [X_WIDTH:0]        w_x_lo;
   logic [X_WIDTH:0]        w_x_hi;
   logic [Y_WIDTH:0]        w_y_lo;
   logic [Y_WIDTH:0]        w_y_hi;
   logic [X_WIDTH:0]        w_px;
   logic [Y_WIDTH:0]        w_py;
   logic                    w_hit_next;

   assign w_strobe = &r_strobe_cnt;
   // A position load in the same cycle suppresses motion.
   assign w_move   = w_strobe & sprite_enable_update & ~sprite_write_xy;

   // Velocity is two's complement; extend to coordinate width for modulo add.
   assign w_dx_ext = {{(X_WIDTH-DX_WIDTH){r_dx[DX_WIDTH-1]}}, r_dx};
   assign w_dy_ext = {{(Y_WIDTH-DY_WIDTH){r_dy[DY_WIDTH-1]}}, r_dy};

   // Sprite extent as [lo, hi) in widened arithmetic.
   assign w_x_lo = {1'b0, r_x};
   assign w_y_lo = {1'b0, r_y};
   assign w_x_hi = w_x_lo + L_SPR_W;
   assign w_y_hi = w_y_lo + L_SPR_H;
   assign w_px   = {1'b0, pixel_x};
   assign w_py   = {1'b0, pixel_y};

   // A wrapped "negative" position lands near 2^W and fails this test naturally.
   assign sprite_within_screen = (w_x_hi <= L_SCR_W) & (w_y_hi <= L_SCR_H);

   assign w_hit_next = (w_px >= w_x_lo) & (w_px < w_x_hi) &
                       (w_py >= w_y_lo) & (w_py < w_y_hi);

   assign sprite_x         = r_x;
   assign sprite_y         = r_y;
   assign sprite_pixel_hit = r_hit;

   // Free-running strobe counter; never re-phased except by reset.
   always_ff @(posedge clk) begin
      if (reset) r_strobe_cnt <= '0;
      else       r_strobe_cnt <= r_strobe_cnt + 1'b1;
   end

   // Position: load has priority over strobe-driven motion.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_x <= '0;
         r_y <= '0;
      end else if (sprite_write_xy) begin
         r_x <= sprite_write_x;
         r_y <= sprite_write_y;
      end else if (w_move) begin
         r_x <= r_x + w_dx_ext;
         r_y <= r_y + w_dy_ext;
      end
   end

   // Velocity: motion this cycle sees the old value, new one applies next strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dx <= '0;
         r_dy <= '0;
      end else if (sprite_write_dxy) begin
         r_dx <= sprite_write_dx;
         r_dy <= sprite_write_dy;
      end
   end

   // Registered pixel coverage against the current-cycle position.
   always_ff @(posedge clk) begin
      if (reset) r_hit <= 1'b0;
      else       r_hit <= w_hit_next;
   end

endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed bench for game_sprite_motion with a 4-cycle strobe period.
module tb_game_sprite_motion;

   logic       clk;
   logic       reset;
   logic       sprite_write_xy;
   logic       sprite_write_dxy;
   logic [9:0] sprite_write_x;
   logic [9:0] sprite_write_y;
   logic [1:0] sprite_write_dx;
   logic [1:0] sprite_write_dy;
   logic       sprite_enable_update;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic [9:0] sprite_x;
   logic [9:0] sprite_y;
   logic       sprite_within_screen;
   logic       sprite_pixel_hit;

   int n_total = 0;
   int n_fail  = 0;
   int tb_cnt  = 0;   // bench model of the strobe counter

   game_sprite_motion #(.STROBE_WIDTH(2)) dut (
      .clk                  (clk),
      .reset                (reset),
      .sprite_write_xy      (sprite_write_xy),
      .sprite_write_dxy     (sprite_write_dxy),
      .sprite_write_x       (sprite_write_x),
      .sprite_write_y       (sprite_write_y),
      .sprite_write_dx      (sprite_write_dx),
      .sprite_write_dy      (sprite_write_dy),
      .sprite_enable_update (sprite_enable_update),
      .pixel_x              (pixel_x),
      .pixel_y              (pixel_y),
      .sprite_x             (sprite_x),
      .sprite_y             (sprite_y),
      .sprite_within_screen (sprite_within_screen),
      .sprite_pixel_hit     (sprite_pixel_hit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock edge; model counter advances, outputs sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      tb_cnt = reset ? 0 : (tb_cnt + 1) % 4;
      #1;
   endtask

   // Advance to the cycle in which the strobe is asserted (counter == 3).
   task automatic to_strobe();
      while (tb_cnt != 3) tick();
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
         $error("check %s differs", tag);
      end
   endtask

   task automatic load_xy(input int x, input int y);
      sprite_write_xy = 1'b1;
      sprite_write_x  = 10'(x);
      sprite_write_y  = 10'(y);
   endtask

   task automatic load_dxy(input logic [1:0] dx, input logic [1:0] dy);
      sprite_write_dxy = 1'b1;
      sprite_write_dx  = dx;
      sprite_write_dy  = dy;
   endtask

   task automatic clr_writes();
      sprite_write_xy  = 1'b0;
      sprite_write_dxy = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      clr_writes();
      sprite_write_x = '0; sprite_write_y = '0;
      sprite_write_dx = '0; sprite_write_dy = '0;
      sprite_enable_update = 1'b0;
      pixel_x = '0; pixel_y = '0;

      // Reset state
      tick();
      chk("rst_x", sprite_x, 0);
      chk("rst_y", sprite_y, 0);
      chk("rst_within", sprite_within_screen, 1);
      chk("rst_hit", sprite_pixel_hit, 0);
      reset = 1'b0;

      // Load (100,50), velocity (+1,-1), then three strobes over 12 cycles
      load_xy(100, 50);
      load_dxy(2'b01, 2'b11);
      tick();
      clr_writes();
      chk("load_x", sprite_x, 100);
      chk("load_y", sprite_y, 50);
      sprite_enable_update = 1'b1;
      repeat (12) tick();
      chk("move3_x", sprite_x, 103);
      chk("move3_y", sprite_y, 47);

      // Enable low: position held while counter runs
      sprite_enable_update = 1'b0;
      repeat (5) tick();
      chk("hold_x", sprite_x, 103);
      chk("hold_y", sprite_y, 47);

      // Pixel coverage at (100,50)
      load_xy(100, 50);
      tick();
      clr_writes();
      pixel_x = 10'd107; pixel_y = 10'd57; tick();
      chk("hit_corner_br", sprite_pixel_hit, 1);
      pixel_x = 10'd108; pixel_y = 10'd57; tick();
      chk("hit_right_out", sprite_pixel_hit, 0);
      pixel_x = 10'd99;  pixel_y = 10'd50; tick();
      chk("hit_left_out", sprite_pixel_hit, 0);
      pixel_x = 10'd100; pixel_y = 10'd50; tick();
      chk("hit_corner_tl", sprite_pixel_hit, 1);
      pixel_x = 10'd100; pixel_y = 10'd58; tick();
      chk("hit_below_out", sprite_pixel_hit, 0);
      pixel_x = '0; pixel_y = '0;

      // Right edge: 632 inside, 633 outside
      load_xy(632, 0);
      load_dxy(2'b01, 2'b00);
      tick();
      clr_writes();
      chk("edge632_within", sprite_within_screen, 1);
      sprite_enable_update = 1'b1;
      to_strobe();
      chk("edge_pre_x", sprite_x, 632);
      chk("edge_pre_within", sprite_within_screen, 1);
      tick();
      chk("edge633_x", sprite_x, 633);
      chk("edge633_within", sprite_within_screen, 0);

      // y wraps below zero
      sprite_enable_update = 1'b0;
      load_xy(10, 0);
      load_dxy(2'b00, 2'b11);
      tick();
      clr_writes();
      chk("wrap_pre_within", sprite_within_screen, 1);
      sprite_enable_update = 1'b1;
      to_strobe();
      tick();
      chk("wrap_y", sprite_y, 1023);
      chk("wrap_x", sprite_x, 10);
      chk("wrap_within", sprite_within_screen, 0);

      // Load colliding with a strobe wins; velocity write on a strobe uses old dx
      sprite_enable_update = 1'b0;
      load_xy(50, 10);
      load_dxy(2'b01, 2'b00);
      tick();
      clr_writes();
      sprite_enable_update = 1'b1;
      to_strobe();
      load_xy(200, 10);
      tick();
      clr_writes();
      chk("loadwins_x", sprite_x, 200);
      to_strobe();
      tick();
      chk("after_load_x", sprite_x, 201);
      to_strobe();
      load_dxy(2'b11, 2'b00);
      tick();
      clr_writes();
      chk("old_dx_x", sprite_x, 202);
      to_strobe();
      tick();
      chk("new_dx_x", sprite_x, 201);

      // Reset mid-motion overrides concurrent writes; strobe re-phases from release
      reset = 1'b1;
      load_xy(5, 5);
      load_dxy(2'b01, 2'b01);
      tick();
      clr_writes();
      chk("rst2_x", sprite_x, 0);
      chk("rst2_y", sprite_y, 0);
      reset = 1'b0;
      load_dxy(2'b01, 2'b00);
      tick();
      clr_writes();
      tick(); tick();
      chk("rst2_nomove_x", sprite_x, 0);
      tick();
      chk("rst2_first_strobe_x", sprite_x, 1);

      $display("%0d/%0d checks passed", n_total - n_fail, n_total);
      $finish;
   end

endmodule
